mul_dispatcher: RTL and testbench
=================================

// Module: mul_dispatcher
// PURPOSE
//  Upstream feeder for the 64x64 sequential multiplier. Buffers operand pairs in a FIFO,
//  drives the multiplier's op_start/op_clear protocol one job at a time, captures the
//  128-bit product on op_done and presents it on a valid/ready output register.
//  Sits between the bus/host command side and the multiplier instance.
// PARAMETERS
//  DEPTH   4    operand FIFO entries; power of two, 2..16
//  AW      2    FIFO pointer width = log2(DEPTH)
// PORTS
//  clk            in   1    single clock, all logic on rising edge
//  reset          in   1    synchronous, active-high reset
//  in_valid       in   1    operand pair offered
//  in_ready       out  1    FIFO not full; push when in_valid & in_ready
//  in_multiplier  in   64   operand A
//  in_multiplicand in  64   operand B
//  mul_multiplier out  64   to multiplier, FIFO head operand A
//  mul_multiplicand out 64  to multiplier, FIFO head operand B
//  mul_op_start   out  1    to multiplier, start request (level)
//  mul_op_clear   out  1    to multiplier, 1-cycle clear pulse
//  mul_op_done    in   1    from multiplier, product valid (held until cleared)
//  mul_result     in   128  from multiplier, product
//  out_valid      out  1    result register full
//  out_ready      in   1    consumer accepts when out_valid & out_ready
//  out_result     out  128  captured product
//  busy           out  1    FSM not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset: FIFO empty, pointers/count 0, FSM IDLE, mul_op_start=0, mul_op_clear=0,
//   out_valid=0, out_result=0, in_ready=1, busy=0. Reset mid-job aborts it; the
//   multiplier sees op_start=0 and no clear pulse (it shares the system reset).
//  FIFO: count 0..DEPTH; in_ready=(count!=DEPTH). Push and pop in same cycle legal when
//   full or empty-with-push? Only pop-when-nonempty; simultaneous push+pop keeps count.
//   Pointers wrap modulo DEPTH. Push ignored when full.
//  mul_multiplier/mul_multiplicand = FIFO head, combinational from storage; stable
//   from START until pop.
//  FSM (2-bit state):
//   IDLE : count!=0 -> START.
//   START: mul_op_start=1; -> WAIT.
//   WAIT : mul_op_start=1; if mul_op_done & !out_valid -> capture mul_result into
//          out_result, set out_valid, -> CLEAR. If mul_op_done & out_valid (output
//          stalled) stay in WAIT, start held, product retained by multiplier.
//   CLEAR: mul_op_start=0, mul_op_clear=1 (exactly one cycle), pop FIFO head; -> IDLE.
//  Latency: push at cycle 0 into empty idle block -> op_start high at cycle 2;
//   out_valid asserts cycle after op_done seen; next job start >= 2 cycles after CLEAR.
//  Capture when out_valid & out_ready same cycle as op_done: treat register as free
//   (drain and refill in same cycle); no bubble.
//  out_valid clears on out_ready unless refilled same cycle. out_result holds otherwise.
//  Width: no arithmetic on data; product passes unchanged, 128 bits.
// CONFIGURATION
//  MUL_DISP_TAG_EN defined: adds ports in_tag (in,4) and out_tag (out,4); tag stored
//   per FIFO entry, copied to out_tag with out_result; out_tag resets to 0.
//  Not defined: no tag ports, no tag storage; all else identical.
// STRUCTURE
//  mul_disp_pkg: localparams for FSM encodings (IDLE=0,START=1,WAIT=2,CLEAR=3),
//   operand/result widths (64/128), tag width 4.
//  One sub-module: mul_disp_fifo (parameterised sync FIFO, DEPTH/AW, width 128 or 132).
//  Top holds FSM, output register, busy logic.
// TESTING
//  Single job: push A=3,B=5; model multiplier done 66 cycles later -> one clear pulse,
//   out_result=15, out_valid=1 until out_ready.
//  Fill: push 4 pairs back-to-back with out_ready=1 -> in_ready=0 after 4th push,
//   results emerge in push order, each job exactly one op_clear pulse.
//  Stall: out_ready=0, two jobs -> second job waits in WAIT with op_start high, no
//   clear until first result drained; then product captured unchanged.
//  Max operands: A=B=64'hFFFF_FFFF_FFFF_FFFF -> out_result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
//  Reset mid-WAIT: assert reset 1 cycle -> all outputs at reset values next cycle,
//   FIFO empty, no spurious out_valid.
//  MUL_DISP_TAG_EN build: tags 1,2,3 pushed -> out_tag 1,2,3 aligned with results.

Source files
------------

// File: rtl/mul_disp_pkg.sv
// Shared definitions for the multiplier dispatcher.
// Holds operand/result/tag widths, the FSM state encoding and the FIFO entry
// width. The entry width grows by the tag width when MUL_DISP_TAG_EN is defined.
package mul_disp_pkg;
  localparam int OP_W  = 64;
  localparam int RES_W = 128;
  localparam int TAG_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    WAIT  = ST_WAIT,
    CLEAR = ST_CLEAR
  } state_e;

`ifdef MUL_DISP_TAG_EN
  localparam int ENT_W = 2*OP_W + TAG_W;
`else
  localparam int ENT_W = 2*OP_W;
`endif
endpackage

// File: rtl/mul_dispatcher_if.sv
// Handshake/bus bundle for mul_dispatcher.
// Groups the operand input side, the multiplier control side, the result
// output side and the busy flag. slave = dispatcher view, master = environment
// view (host, multiplier and result consumer). Tag signals exist only when
// MUL_DISP_TAG_EN is defined.
interface mul_dispatcher_if;
  import mul_disp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_multiplier;
  logic [OP_W-1:0]  in_multiplicand;
  logic [OP_W-1:0]  mul_multiplier;
  logic [OP_W-1:0]  mul_multiplicand;
  logic             mul_op_start;
  logic             mul_op_clear;
  logic             mul_op_done;
  logic [RES_W-1:0] mul_result;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic             busy;
`ifdef MUL_DISP_TAG_EN
  logic [TAG_W-1:0] in_tag;
  logic [TAG_W-1:0] out_tag;
`endif

  modport slave (
    input  in_valid, in_multiplier, in_multiplicand, mul_op_done, mul_result, out_ready,
    output in_ready, mul_multiplier, mul_multiplicand, mul_op_start, mul_op_clear,
           out_valid, out_result, busy
`ifdef MUL_DISP_TAG_EN
    , input in_tag, output out_tag
`endif
  );

  modport master (
    output in_valid, in_multiplier, in_multiplicand, mul_op_done, mul_result, out_ready,
    input  in_ready, mul_multiplier, mul_multiplicand, mul_op_start, mul_op_clear,
           out_valid, out_result, busy
`ifdef MUL_DISP_TAG_EN
    , output in_tag, input out_tag
`endif
  );
endinterface

// File: rtl/mul_disp_fifo.sv
// Parameterised synchronous FIFO for operand entries.
// Ports: clk, reset (sync, active high), i_push/i_wdata (ignored when full),
// i_pop (ignored when empty), o_rdata (head, combinational from storage),
// o_full, o_empty. DEPTH must equal 2**AW so pointers wrap naturally.
module mul_disp_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mul_dispatcher.sv
// Upstream feeder for the 64x64 sequential multiplier.
// Buffers operand pairs, runs one multiplier job at a time with the
// op_start (level) / op_clear (1-cycle pulse) protocol, captures the 128-bit
// product and presents it on a valid/ready output register.
// Ports: clk, reset (sync, active high), bus (mul_dispatcher_if.slave).
// Optional feature macro: MUL_DISP_TAG_EN adds a 4-bit tag carried per job.
module mul_dispatcher
  import mul_disp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic             clk,
  input logic             reset,
  mul_dispatcher_if.slave bus
);
  state_e           r_state, w_state_nxt;
  logic             w_start, w_clear, w_pop, w_capture;
  logic             w_full, w_empty;
  logic [ENT_W-1:0] w_wdata, w_head;
  logic             r_out_valid;
  logic [RES_W-1:0] r_out_result;

`ifdef MUL_DISP_TAG_EN
  logic [TAG_W-1:0] r_out_tag;
  assign w_wdata     = {bus.in_tag, bus.in_multiplier, bus.in_multiplicand};
  assign bus.out_tag = r_out_tag;
`else
  assign w_wdata = {bus.in_multiplier, bus.in_multiplicand};
`endif

  mul_disp_fifo #(.DEPTH(DEPTH), .AW(AW), .W(ENT_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.in_valid),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head stays put from START until the pop in CLEAR, so the multiplier
  // sees stable operands for the whole job.
  assign bus.mul_multiplier   = w_head[2*OP_W-1:OP_W];
  assign bus.mul_multiplicand = w_head[OP_W-1:0];
  assign bus.in_ready         = ~w_full;
  assign bus.mul_op_start     = w_start;
  assign bus.mul_op_clear     = w_clear;
  assign bus.out_valid        = r_out_valid;
  assign bus.out_result       = r_out_result;
  assign bus.busy             = (r_state != IDLE) | ~w_empty;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_clear     = 1'b0;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE:  if (!w_empty) w_state_nxt = START;
      START: begin
        w_start     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_start = 1'b1;
        // A register being drained this cycle counts as free: no bubble.
        // When stalled, the multiplier keeps the product until we clear it.
        if (bus.mul_op_done && (!r_out_valid || bus.out_ready)) begin
          w_capture   = 1'b1;
          w_state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        w_clear     = 1'b1;
        w_pop       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
`ifdef MUL_DISP_TAG_EN
      r_out_tag    <= '0;
`endif
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= bus.mul_result;
`ifdef MUL_DISP_TAG_EN
      r_out_tag    <= w_head[ENT_W-1 -: TAG_W];
`endif
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mul_dispatcher.sv
// Self-checking bench for mul_dispatcher: behavioural multiplier model,
// queue-based scoreboard of expected products, directed plus random phases.
module tb_mul_dispatcher;
  import mul_disp_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mul_dispatcher_if bus();

  mul_dispatcher #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [RES_W+TAG_W-1:0] obs,
                     input logic [RES_W+TAG_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Multiplier model: starts on op_start, raises done mul_lat cycles later,
  // holds done and product until op_clear.
  int         mul_lat = 66;
  int         m_cnt;
  logic       m_busy;
  always @(posedge clk) begin
    if (reset) begin
      bus.mul_op_done <= 1'b0;
      m_busy          <= 1'b0;
      m_cnt           <= 0;
    end else if (bus.mul_op_clear) begin
      bus.mul_op_done <= 1'b0;
      m_busy          <= 1'b0;
    end else if (bus.mul_op_start && !m_busy && !bus.mul_op_done) begin
      m_busy         <= 1'b1;
      m_cnt          <= mul_lat;
      bus.mul_result <= {64'd0, bus.mul_multiplier} * {64'd0, bus.mul_multiplicand};
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        bus.mul_op_done <= 1'b1;
        m_busy          <= 1'b0;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  typedef struct {
    logic [RES_W-1:0] p;
    logic [TAG_W-1:0] t;
  } exp_t;
  exp_t q[$];
  int   results = 0;
  int   clears = 0;
  logic pushed_now;

  // One clock: observe handshakes at the edge (pre-update values), then step
  // 1 time unit past it so the caller can drive and sample safely.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    pushed_now = 1'b0;
    if (reset) q.delete();
    else begin
      if (bus.mul_op_clear) clears++;
      if (bus.out_valid && bus.out_ready) begin
        chk("out_expected", (q.size() != 0), 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_result", bus.out_result, e.p);
`ifdef MUL_DISP_TAG_EN
          chk("out_tag", bus.out_tag, e.t);
`endif
        end
        results++;
      end
      if (bus.in_valid && bus.in_ready) begin
        e.p = {64'd0, bus.in_multiplier} * {64'd0, bus.in_multiplicand};
`ifdef MUL_DISP_TAG_EN
        e.t = bus.in_tag;
`else
        e.t = '0;
`endif
        q.push_back(e);
        pushed_now = 1'b1;
      end
    end
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
    int n = 0;
    bus.in_valid        = 1'b1;
    bus.in_multiplier   = a;
    bus.in_multiplicand = b;
`ifdef MUL_DISP_TAG_EN
    bus.in_tag = tag;
`else
    if (tag != 0) n = 0;
`endif
    do begin tick(); n++; end while (!pushed_now && n < 500);
    if (!pushed_now) chk("push_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin tick(); n++; end
    chk("out_valid_seen", bus.out_valid, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.busy || bus.out_valid || q.size() != 0) && n < budget) begin tick(); n++; end
    chk("drain_done", (bus.busy || bus.out_valid || q.size() != 0), 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready, 1'b1);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_result"}, bus.out_result, '0);
    chk({tag, "_start"},     bus.mul_op_start, 1'b0);
    chk({tag, "_clear"},     bus.mul_op_clear, 1'b0);
    chk({tag, "_busy"},      bus.busy, 1'b0);
`ifdef MUL_DISP_TAG_EN
    chk({tag, "_out_tag"},   bus.out_tag, '0);
`endif
  endtask

  initial begin
    int c0, r0, n;
    logic [127:0] first_p;
    bus.in_valid        = 1'b0;
    bus.in_multiplier   = '0;
    bus.in_multiplicand = '0;
    bus.out_ready       = 1'b0;
`ifdef MUL_DISP_TAG_EN
    bus.in_tag = '0;
`endif
    reset = 1'b1;
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Single job 3*5 with a 66-cycle multiplier, latency checks.
    c0 = clears;
    push(64'd3, 64'd5, 4'd1);
    chk("lat_c1_start", bus.mul_op_start, 1'b0);
    chk("lat_c1_busy",  bus.busy, 1'b1);
    tick();
    chk("lat_c2_start", bus.mul_op_start, 1'b1);
    wait_out_valid(200);
    chk("single_result", bus.out_result, 128'd15);
    repeat (5) tick();
    chk("single_clears", clears - c0, 1);
    chk("single_hold_valid", bus.out_valid, 1'b1);
    chk("single_hold_result", bus.out_result, 128'd15);
    chk("single_idle", bus.busy, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("single_drained", bus.out_valid, 1'b0);

    // Max operands.
    push(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd2);
    wait_out_valid(200);
    chk("max_result", bus.out_result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    bus.out_ready = 1'b1;
    wait_idle(50);

    // Fill four back-to-back, tags 1..4.
    c0 = clears; r0 = results;
    for (int i = 0; i < 4; i++) push(64'($urandom), 64'($urandom), 4'(i + 1));
    chk("fill_in_ready", bus.in_ready, 1'b0);
    wait_idle(2000);
    chk("fill_results", results - r0, 4);
    chk("fill_clears",  clears - c0, 4);

    // Stall: first result held, second job sits in WAIT with start high.
    bus.out_ready = 1'b0;
    mul_lat = 10;
    c0 = clears; r0 = results;
    first_p = 128'd7 * 128'd9;
    push(64'd7, 64'd9, 4'd3);
    push(64'hDEAD_BEEF_0000_1234, 64'h0000_0001_0000_0003, 4'd4);
    wait_out_valid(200);
    repeat (40) tick();
    chk("stall_start", bus.mul_op_start, 1'b1);
    chk("stall_clear", bus.mul_op_clear, 1'b0);
    chk("stall_clears", clears - c0, 1);
    chk("stall_result", bus.out_result, first_p);
    chk("stall_busy", bus.busy, 1'b1);
    bus.out_ready = 1'b1;
    wait_idle(200);
    chk("stall_results", results - r0, 2);
    chk("stall_clears_total", clears - c0, 2);

    // Random traffic with random handshakes and multiplier latency.
    c0 = clears; r0 = results; n = 0;
    for (int cyc = 0; cyc < 3000 && n < 24; cyc++) begin
      bus.in_valid        = 1'($urandom_range(0, 1));
      bus.in_multiplier   = {$urandom, $urandom};
      bus.in_multiplicand = {$urandom, $urandom};
`ifdef MUL_DISP_TAG_EN
      bus.in_tag = 4'($urandom);
`endif
      bus.out_ready = 1'($urandom_range(0, 1));
      mul_lat = $urandom_range(1, 8);
      tick();
      if (pushed_now) n++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("rand_pushes", n, 24);
    wait_idle(2000);
    chk("rand_results", results - r0, 24);
    chk("rand_clears",  clears - c0, 24);

    // Reset in the middle of WAIT with a second job queued.
    bus.out_ready = 1'b0;
    mul_lat = 66;
    push(64'd11, 64'd13, 4'd5);
    push(64'd17, 64'd19, 4'd6);
    repeat (10) tick();
    chk("pre_rst_start", bus.mul_op_start, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("midrst");
    repeat (100) tick();
    chk("post_rst_valid", bus.out_valid, 1'b0);
    chk("post_rst_busy", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
